// File: rtl/gait_cmd_if.sv
// Command channel for the gait sequencer: START/STOP requests carried over valid/ready.
// The master drives the command fields and valid; the slave answers with ready.
interface gait_cmd_if #(
  parameter int GW = 2
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [GW-1:0] cmd_gait;
  logic          cmd_dir;
  logic [1:0]    cmd_speed;

  modport master (
    output cmd_valid, cmd_op, cmd_gait, cmd_dir, cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_gait, cmd_dir, cmd_speed,
    output cmd_ready
  );
endinterface

// File: rtl/gait_sequencer.sv
// Drives the gait-ROM address {gait, frame} from a programmable timebase.
// Gait, direction and speed only switch on frame 0, so a stride is never cut short.
module gait_sequencer #(
  parameter int GW         = 2,
  parameter int FW         = 5,
  parameter int BASE_DELAY = 720000
) (
  input  logic           clk,
  input  logic           rst,
  gait_cmd_if.slave      cmd,
  output logic [GW+FW-1:0] o_addr,
  output logic           o_frame_tic,
  output logic           o_cycle_done,
  output logic           o_running,
  output logic           o_pending
);

  localparam int PW = (BASE_DELAY > 1) ? $clog2(BASE_DELAY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic [1:0]    r_step_cnt, w_step_cnt_next;
  logic [FW-1:0] r_frame, w_frame_next;
  logic [GW-1:0] r_gait, w_gait_next;
  logic          r_dir, w_dir_next;
  logic [1:0]    r_speed, w_speed_next;
  logic          r_pend, w_pend_next;
  logic [GW-1:0] r_pgait, w_pgait_next;
  logic          r_pdir, w_pdir_next;
  logic [1:0]    r_pspeed, w_pspeed_next;
  logic          r_frame_tic, r_cycle_done;

  logic          w_base_tic, w_step, w_land0;
  logic          w_accept, w_start, w_stop;
  logic [FW-1:0] w_frame_adv;

  assign cmd.cmd_ready = !rst && (r_state != S_DRAIN);

  assign w_accept = cmd.cmd_valid && cmd.cmd_ready;
  assign w_start  = w_accept && !cmd.cmd_op;
  assign w_stop   = w_accept && cmd.cmd_op;

  assign w_base_tic  = (r_state != S_IDLE) && (r_presc == PW'(BASE_DELAY - 1));
  assign w_step      = w_base_tic && (r_step_cnt == (2'd3 - r_speed));
  assign w_frame_adv = r_dir ? (r_frame - FW'(1)) : (r_frame + FW'(1));
  assign w_land0     = w_step && (w_frame_adv == '0);

  always_comb begin
    w_state_next    = r_state;
    w_presc_next    = w_base_tic ? '0 : (r_presc + PW'(1));
    w_step_cnt_next = w_step ? 2'd0 : (w_base_tic ? (r_step_cnt + 2'd1) : r_step_cnt);
    w_frame_next    = w_step ? w_frame_adv : r_frame;
    w_gait_next     = r_gait;
    w_dir_next      = r_dir;
    w_speed_next    = r_speed;
    w_pend_next     = r_pend;
    w_pgait_next    = r_pgait;
    w_pdir_next     = r_pdir;
    w_pspeed_next   = r_pspeed;

    case (r_state)
      S_IDLE: begin
        // Timebase stays cleared so the first step is one full frame period after START.
        w_presc_next    = '0;
        w_step_cnt_next = 2'd0;
        w_frame_next    = '0;
        if (w_start) begin
          w_gait_next  = cmd.cmd_gait;
          w_dir_next   = cmd.cmd_dir;
          w_speed_next = cmd.cmd_speed;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_stop) begin
          w_pend_next = 1'b0;
          if ((r_frame == '0 && !w_step) || w_land0)
            w_state_next = S_IDLE;
          else
            w_state_next = S_DRAIN;
        end else begin
          if (w_land0 && r_pend) begin
            w_gait_next  = r_pgait;
            w_dir_next   = r_pdir;
            w_speed_next = r_pspeed;
            w_pend_next  = 1'b0;
          end
          // A START arriving on the boundary cycle queues for the following boundary.
          if (w_start) begin
            w_pgait_next  = cmd.cmd_gait;
            w_pdir_next   = cmd.cmd_dir;
            w_pspeed_next = cmd.cmd_speed;
            w_pend_next   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_land0)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_step_cnt   <= 2'd0;
      r_frame      <= '0;
      r_gait       <= '0;
      r_dir        <= 1'b0;
      r_speed      <= 2'd0;
      r_pend       <= 1'b0;
      r_pgait      <= '0;
      r_pdir       <= 1'b0;
      r_pspeed     <= 2'd0;
      r_frame_tic  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_step_cnt   <= w_step_cnt_next;
      r_frame      <= w_frame_next;
      r_gait       <= w_gait_next;
      r_dir        <= w_dir_next;
      r_speed      <= w_speed_next;
      r_pend       <= w_pend_next;
      r_pgait      <= w_pgait_next;
      r_pdir       <= w_pdir_next;
      r_pspeed     <= w_pspeed_next;
      r_frame_tic  <= w_step;
      r_cycle_done <= w_land0;
    end
  end

  assign o_addr       = {r_gait, r_frame};
  assign o_frame_tic  = r_frame_tic;
  assign o_cycle_done = r_cycle_done;
  assign o_running    = (r_state != S_IDLE);
  assign o_pending    = r_pend;

endmodule

// File: doc/gait_sequencer.md
Name: gait_sequencer

Overview:
- Sequences the gait-ROM address bus for the hexapod servo datapath. It replaces the free-running address counter with a controlled one.
- Accepts START/STOP commands over a valid/ready handshake. Each command selects gait bank, direction and speed.
- Advances the frame index on a programmable timebase.
- Gait, direction and speed changes take effect only at a gait-cycle boundary (frame 0), so the legs never jump mid-stride.

Parameters:
- GW, 2, gait-select width; 2^GW gait banks in ROM.
- FW, 5, frame-index width; 2^FW frames per gait cycle.
- BASE_DELAY, 720000, clk cycles per base tick (60 ms at 12 MHz); must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready on a rising clk edge
- cmd_op  in  1  0 = START, 1 = STOP
- cmd_gait  in  GW  gait bank for START
- cmd_dir  in  1  0 = forward (frame+1), 1 = reverse (frame-1)
- cmd_speed  in  2  0 slowest … 3 fastest
- addr  out  GW+FW  ROM address = {gait, frame}
- frame_tic  out  1  1-cycle pulse in the first cycle addr holds a new frame
- cycle_done  out  1  1-cycle pulse when frame returns to 0 by stepping
- running  out  1  high in RUN and DRAIN
- pending  out  1  a START is queued for the next boundary

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - state = IDLE
  - addr = 0
  - frame_tic = 0, cycle_done = 0, running = 0, pending = 0
  - prescaler = 0, step counter = 0
  - latched gait/dir/speed = 0
- Reset mid-run: everything returns to reset values on the next edge; any queued command is discarded.
- States: IDLE, RUN, DRAIN.
- cmd_ready = 1 in IDLE and RUN, 0 in DRAIN and while rst is high.
- Timebase:
  - The prescaler counts 0..BASE_DELAY-1 while state != IDLE. It produces base_tic when the count equals BASE_DELAY-1, then wraps to 0.
  - It is cleared on the IDLE->RUN transition.
  - The step counter counts base_tics. When a base_tic arrives with step_cnt == 3-speed, the counter clears and the frame steps.
  - Frame period is therefore BASE_DELAY*(4-speed) cycles.
- Frame step:
  - Forward: frame <= frame+1 mod 2^FW. Reverse: frame <= frame-1 mod 2^FW.
  - frame_tic is registered and asserted in the same cycle the new addr appears.
  - cycle_done is asserted with frame_tic when the new frame == 0.
- IDLE:
  - frame is held at 0; the gait field holds its last value (0 after reset).
  - START accepted: latch gait, dir and speed. addr becomes {cmd_gait,0} next cycle. running = 1 and state goes to RUN.
  - The first step occurs one full frame period later.
  - STOP accepted in IDLE: no effect.
- RUN:
  - START accepted: the command is stored in the pending register and pending = 1. A later START overwrites the stored one.
  - At the next step landing on frame 0, the pending gait/dir/speed become active in that same cycle, so addr = {new_gait,0}. pending then clears and the new speed governs the following period.
  - STOP accepted:
    - Pending is cleared.
    - If frame == 0 and no step occurs that cycle, go to IDLE next cycle and running = 0.
    - Otherwise go to DRAIN.
  - STOP accepted in the same cycle a step lands on frame 0: go to IDLE; running drops the next cycle.
- DRAIN:
  - Keep stepping at the current speed and direction.
  - On the step that lands on frame 0: cycle_done pulses, state goes to IDLE and running = 0 from the next cycle.
  - addr holds {gait,0}.
- No arithmetic overflow beyond the modulo-2^FW frame wrap. The gait field never changes except at frame 0.

Test Plan:
(All tests: GW=2, FW=5, BASE_DELAY=4.)
- Reset: assert rst for 2 cycles during RUN at frame 9 -> next cycle addr=0, running=0, pending=0, cmd_ready=1; no frame_tic for 20 cycles.
- START gait=1, dir=0, speed=3 accepted at cycle T:
  - addr=32 and running=1 at T+1.
  - addr=33 with frame_tic at T+5, then one step every 4 cycles.
  - After 32 steps addr=32 with cycle_done=1.
- Speed: START gait=0, speed=0 -> frame_tic spacing is exactly 16 cycles; with speed=2 it is 8 cycles.
- Reverse: START gait=2, dir=1, speed=3 -> first step addr=95 (bank 64, frame 31), then 94, 93…; cycle_done on the step returning to 64.
- Boundary change: running gait=1 forward, START gait=3, dir=0, speed=1 at frame 10 -> pending=1, addr continues 43..63; the next step gives addr=96 with cycle_done=1 and pending=0; subsequent spacing is 12 cycles.
- STOP at frame 10 of gait 1:
  - cmd_ready=0 and running=1 while frames 11..31 continue.
  - The step to frame 0 gives addr=32, cycle_done=1, then running=0 and cmd_ready=1.
  - A new START is accepted the next cycle.
